// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave in front of a flat register bank.
// Issues byte-merged one-cycle write strobes and returns live values.
module axil_reg_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS-1:0]            REG_WEN,
  output logic [DATA_WIDTH-1:0]          REG_WDATA,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_RDATA
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int XW = ADDR_WIDTH - 2;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [XW:0] NREG = NUM_REGS[XW:0];
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_STROBE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t ws, ws_n;
  rstate_t rs, rs_n;

  logic [DATA_WIDTH-1:0] bank [NUM_REGS];
  logic [XW-1:0] waddr_q, widx, ridx;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_e;
  logic [DATA_WIDTH-1:0] cur, merged;
  logic [SW-1:0] wstrb_q, wstrb_e;
  logic aw_held, w_held, aw_held_n, w_held_n;
  logic aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic w_inr, r_inr;
  logic awready_n, wready_n, bvalid_n;
  logic arready_n, rvalid_n;
  logic [1:0] bresp_n, rresp_n;
  logic [NUM_REGS-1:0] wen_n;
  logic [DATA_WIDTH-1:0] regwd_n, rdata_n;
  logic unused;

  // Byte lanes below the word are ignored.
  assign unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      bank[i] = REG_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Use the held copy if captured earlier, else the live channel.
  always_comb begin
    aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    aw_have = aw_held | aw_hs;
    w_have  = w_held | w_hs;
    widx    = aw_held ? waddr_q
                      : S_AXI_AWADDR[ADDR_WIDTH-1:2];
    wdata_e = w_held ? wdata_q : S_AXI_WDATA;
    wstrb_e = w_held ? wstrb_q : S_AXI_WSTRB;
    w_inr   = {1'b0, widx} < NREG;
    cur     = bank[widx[IW-1:0]];
    for (int b = 0; b < SW; b++)
      merged[b*8 +: 8] = wstrb_e[b] ? wdata_e[b*8 +: 8]
                                    : cur[b*8 +: 8];
  end

  always_comb begin
    ws_n      = ws;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    awready_n = 1'b0;
    wready_n  = 1'b0;
    bvalid_n  = S_AXI_BVALID;
    bresp_n   = S_AXI_BRESP;
    wen_n     = '0;
    regwd_n   = '0;
    unique case (ws)
      W_IDLE: begin
        aw_held_n = aw_have;
        w_held_n  = w_have;
        if (aw_have && w_have) begin
          ws_n      = W_STROBE;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          if (w_inr) begin
            wen_n   = {{(NUM_REGS-1){1'b0}}, 1'b1} << widx;
            regwd_n = merged;
            bresp_n = OKAY;
          end else begin
            bresp_n = SLVERR;
          end
        end else begin
          awready_n = ~aw_have;
          wready_n  = ~w_have;
        end
      end
      W_STROBE: begin
        ws_n     = W_RESP;
        bvalid_n = 1'b1;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          ws_n      = W_IDLE;
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: ws_n = W_IDLE;
    endcase
  end

  always_comb begin
    ridx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    r_inr     = {1'b0, ridx} < NREG;
    ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    rs_n      = rs;
    arready_n = 1'b0;
    rvalid_n  = S_AXI_RVALID;
    rdata_n   = S_AXI_RDATA;
    rresp_n   = S_AXI_RRESP;
    unique case (rs)
      R_IDLE: begin
        if (ar_hs) begin
          rs_n     = R_DATA;
          rvalid_n = 1'b1;
          rdata_n  = r_inr ? bank[ridx[IW-1:0]] : '0;
          rresp_n  = r_inr ? OKAY : SLVERR;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rs_n      = R_IDLE;
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ws            <= W_IDLE;
      rs            <= R_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= '0;
      REG_WEN       <= '0;
      REG_WDATA     <= '0;
    end else begin
      ws            <= ws_n;
      rs            <= rs_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      if (aw_hs)
        waddr_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      S_AXI_AWREADY <= awready_n;
      S_AXI_WREADY  <= wready_n;
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_BRESP   <= bresp_n;
      S_AXI_ARREADY <= arready_n;
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_RDATA   <= rdata_n;
      S_AXI_RRESP   <= rresp_n;
      REG_WEN       <= wen_n;
      REG_WDATA     <= regwd_n;
    end
  end

endmodule
